// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command constants and frame helpers
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    localparam int PS2_TX_BITS = 11;

    // Frame position 0 is the start bit, 1..8 data LSB first, 9 parity, 10 stop.
    function automatic logic ps2_frame_bit(input logic [7:0] data,
                                           input logic       parity,
                                           input logic [3:0] pos);
        logic       b;
        logic [2:0] idx;
        b   = 1'b1;
        idx = 3'(pos - 4'd1);
        if (pos == 4'd0) begin
            b = 1'b0;
        end else if (pos <= 4'd8) begin
            b = data[idx];
        end else if (pos == 4'd9) begin
            b = parity;
        end
        return b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - two-flop synchroniser with falling-edge detect for one PS/2 line
module ps2_line_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic line_i,
    output logic level_o,
    output logic fe_o
);

    logic meta_q;
    logic sync_d0_q;
    logic sync_d1_q;

    // Idle bus level is high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            meta_q    <= 1'b1;
            sync_d0_q <= 1'b1;
            sync_d1_q <= 1'b1;
        end else begin
            meta_q    <= line_i;
            sync_d0_q <= meta_q;
            sync_d1_q <= sync_d0_q;
        end
    end

    assign level_o = sync_d0_q;
    assign fe_o    = sync_d1_q & ~sync_d0_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter with open-drain line enables
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_dat_oe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       SHIFT_LAST   = 4'(PS2_TX_BITS - 2);
    localparam logic [3:0]       BIT_SAT      = 4'(PS2_TX_BITS);

    ps2_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [7:0]       data_q;
    logic             parity_q;
    logic             ack_err_q;
    logic             tx_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             clk_oe_q;
    logic             dat_oe_q;

    logic             clk_level;
    logic             clk_fe;
    logic             dat_level;
    logic             dat_fe_unused;

    ps2_line_sync u_clk_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .line_i  (ps2_clk_i),
        .level_o (clk_level),
        .fe_o    (clk_fe)
    );

    ps2_line_sync u_dat_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .line_i  (ps2_dat_i),
        .level_o (dat_level),
        .fe_o    (dat_fe_unused)
    );

    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       bit_cnt_d;
    logic             frame_bit_d;
    logic             in_frame;
    logic             timed_out;

    assign cnt_d       = cnt_q + 1'b1;
    assign bit_cnt_d   = (bit_cnt_q == BIT_SAT) ? bit_cnt_q : bit_cnt_q + 4'd1;
    assign frame_bit_d = ps2_frame_bit(data_q, parity_q, bit_cnt_d);
    // The timeout window opens at REQ and also covers the wait for the lines to go idle.
    assign in_frame    = (state_q == REQ) || (state_q == SHIFT) ||
                         (state_q == ACK) || (state_q == WAIT_IDLE);
    assign timed_out   = in_frame && (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            parity_q   <= 1'b0;
            ack_err_q  <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (timed_out) begin
                state_q    <= IDLE;
                clk_oe_q   <= 1'b0;
                dat_oe_q   <= 1'b0;
                done_q     <= 1'b1;
                err_q      <= 1'b1;
                tx_ready_q <= 1'b1;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        clk_oe_q   <= 1'b0;
                        dat_oe_q   <= 1'b0;
                        busy_q     <= 1'b0;
                        tx_ready_q <= 1'b1;
                        if (tx_valid_i && tx_ready_q) begin
                            data_q     <= tx_data_i;
                            parity_q   <= ~^tx_data_i;
                            tx_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            clk_oe_q   <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (cnt_q == INHIBIT_LAST) begin
                            dat_oe_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= REQ;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    REQ: begin
                        clk_oe_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        cnt_q     <= cnt_d;
                        state_q   <= SHIFT;
                    end
                    SHIFT: begin
                        cnt_q <= cnt_d;
                        if (clk_fe) begin
                            dat_oe_q  <= ~frame_bit_d;
                            bit_cnt_q <= bit_cnt_d;
                            if (bit_cnt_q == SHIFT_LAST) begin
                                state_q <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        cnt_q <= cnt_d;
                        if (clk_fe) begin
                            ack_err_q <= dat_level;
                            bit_cnt_q <= bit_cnt_d;
                            state_q   <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        cnt_q <= cnt_d;
                        if (clk_level && dat_level) begin
                            state_q    <= IDLE;
                            done_q     <= 1'b1;
                            err_q      <= ack_err_q;
                            tx_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready_o   = tx_ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign ps2_clk_oe_o = clk_oe_q;
    assign ps2_dat_oe_o = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a behavioural PS/2 device
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 6000;
    localparam int TO   = 3000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       clk_oe;
    logic       dat_oe;
    logic       dev_clk_low;
    logic       dev_dat_low;
    logic       ps2_clk_pin;
    logic       ps2_dat_pin;

    always #5 clk = ~clk;

    assign ps2_clk_pin = ~(clk_oe | dev_clk_low);
    assign ps2_dat_pin = ~(dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .ps2_clk_i    (ps2_clk_pin),
        .ps2_dat_i    (ps2_dat_pin),
        .ps2_clk_oe_o (clk_oe),
        .ps2_dat_oe_o (dat_oe),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at cycle %0d, required event never seen", name, cyc);
    endtask

    // Reference frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (($countones(d) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    typedef struct {
        logic [7:0] data;
        bit         err;
        bit         timeout;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [10:0] dev_bits;
    int          req_cyc   = 0;
    bit          prev_done = 1'b0;

    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending transaction", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_err", {31'd0, err}, {31'd0, mon_e.err});
                check("ready_at_done", {31'd0, tx_ready}, 32'd1);
                check("oe_at_done", {30'd0, clk_oe, dat_oe}, 32'd0);
                if (mon_e.timeout)
                    check("timeout_latency", cyc - req_cyc, TO);
                else
                    check("frame_bits", {21'd0, dev_bits}, {21'd0, exp_frame(mon_e.data)});
            end
        end
        prev_done = (reset === 1'b1) && (done === 1'b1);
    end

    int inh_run = 0;
    bit chk_rel = 1'b0;

    always @(negedge clk) begin
        if (chk_rel) begin
            check("req_release", {30'd0, clk_oe, dat_oe}, 32'd1);
            chk_rel = 1'b0;
        end else if (clk_oe === 1'b1 && dat_oe === 1'b1) begin
            check("inhibit_len", inh_run, INH);
            req_cyc = cyc;
            chk_rel = 1'b1;
        end
        inh_run = (clk_oe === 1'b1 && dat_oe === 1'b0) ? inh_run + 1 : 0;
    end

    int n_accept   = 0;
    bit prev_ready = 1'b0;

    always @(negedge clk) begin
        if (reset === 1'b1 && prev_ready && tx_ready === 1'b0) n_accept++;
        prev_ready = (tx_ready === 1'b1);
    end

    task automatic issue(input logic [7:0] d, input bit hold, input bit expect_done,
                         input bit exp_err, input bit is_to);
        int w;
        for (w = 0; w < 20000; w++) begin
            if (tx_ready === 1'b1) break;
            @(negedge clk);
        end
        if (w == 20000) fail_bound("issue_ready");
        tx_data  = d;
        tx_valid = 1'b1;
        if (expect_done) exp_q.push_back('{data: d, err: exp_err, timeout: is_to});
        @(negedge clk);
        check("accept_busy", {31'd0, busy}, 32'd1);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic run_device(input bit ack, input int n_fe);
        int         w;
        logic [3:0] bi;
        for (w = 0; w < 20000; w++) begin
            if (ps2_clk_pin === 1'b0) break;
            @(negedge clk);
        end
        if (w == 20000) begin
            fail_bound("device_inhibit");
            return;
        end
        for (w = 0; w < 20000; w++) begin
            if (ps2_clk_pin === 1'b1 && ps2_dat_pin === 1'b0) break;
            @(negedge clk);
        end
        if (w == 20000) begin
            fail_bound("device_request");
            return;
        end
        for (int i = 0; i < n_fe; i++) begin
            repeat (HALF) @(negedge clk);
            bi = 4'(i);
            dev_bits[bi] = ps2_dat_pin;
            if (i == 10 && ack) begin
                dev_dat_low = 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
        end
        if (dev_dat_low) begin
            repeat (5) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w;
        for (w = 0; w < 20000; w++) begin
            @(negedge clk);
            if (tx_ready === 1'b1 && busy === 1'b0) break;
        end
        if (w == 20000) fail_bound("wait_idle");
    endtask

    initial begin
        logic [7:0] rnd;
        bit         ack;
        int         acc0;

        reset       = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        dev_bits    = '0;
        repeat (3) @(negedge clk);
        check("reset_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_clk_oe", {31'd0, clk_oe}, 32'd0);
        check("reset_dat_oe", {31'd0, dat_oe}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, tx_ready}, 32'd1);

        issue(PS2_CMD_SET_LED, 1'b0, 1'b1, 1'b0, 1'b0);
        run_device(1'b1, 11);
        wait_idle();

        issue(PS2_CMD_ENABLE, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_idle();

        issue(8'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
        run_device(1'b0, 11);
        wait_idle();

        issue(PS2_CMD_ENABLE, 1'b0, 1'b0, 1'b0, 1'b0);
        run_device(1'b1, 4);
        reset = 1'b0;
        @(negedge clk);
        check("abort_clk_oe", {31'd0, clk_oe}, 32'd0);
        check("abort_dat_oe", {31'd0, dat_oe}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(PS2_CMD_ENABLE, 1'b0, 1'b1, 1'b0, 1'b0);
        run_device(1'b1, 11);
        wait_idle();

        acc0 = n_accept;
        issue(PS2_CMD_RESET, 1'b1, 1'b1, 1'b0, 1'b0);
        run_device(1'b1, 11);
        issue(PS2_CMD_SET_LED, 1'b1, 1'b1, 1'b0, 1'b0);
        run_device(1'b1, 11);
        rnd = 8'($urandom);
        ack = 1'($urandom);
        issue(rnd, 1'b0, 1'b1, !ack, 1'b0);
        run_device(ack, 11);
        wait_idle();
        repeat (50) @(negedge clk);
        check("accepts_back_to_back", n_accept - acc0, 3);

        rnd = 8'($urandom);
        ack = 1'($urandom);
        issue(rnd, 1'b0, 1'b1, !ack, 1'b0);
        run_device(ack, 11);
        wait_idle();

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        repeat (150000) @(posedge clk);
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation reached cycle %0d, required completion earlier", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
